// File: rtl/vga_pkg.sv
// Shared VGA definitions: default bus widths, arbiter state encoding and
// the 320x240 frame geometry used by the fetcher and timing blocks.
package vga_pkg;

  localparam int ADDR_W_DEF  = 17;
  localparam int DATA_W_DEF  = 12;

  localparam int FRAME_W     = 320;
  localparam int FRAME_H     = 240;
  localparam int FRAME_WORDS = FRAME_W * FRAME_H;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DISP = 2'd1,
    HOST = 2'd2
  } arb_state_t;

endpackage

// File: rtl/vga_fb_arb_rdpipe.sv
// Display read-return path: two-stage valid pipeline that tracks a display
// grant through the RAM command register and the RAM read latency, plus the
// read-data passthrough (zeroed whenever the data is not valid).
module vga_fb_arb_rdpipe
  import vga_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_issue,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata
);

  logic rd_inflight;

  // Shift the grant through the command stage and the RAM latency stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_inflight <= 1'b0;
      rvalid      <= 1'b0;
    end else begin
      rd_inflight <= rd_issue;
      rvalid      <= rd_inflight;
    end
  end

  // Pass RAM data through only while it belongs to a display read.
  always_comb begin
    rdata = rvalid ? mem_rdata : '0;
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: shares one single-port synchronous pixel RAM between
// the VGA scan-out fetcher (reads) and a host writer.
// Optional statistics counters are enabled with macro VGA_FB_ARB_STATS_EN.
//
// state | meaning
// IDLE  | no grant issued last cycle
// DISP  | display read granted last cycle (RAM read command now on the bus)
// HOST  | host write granted last cycle (RAM write command now on the bus)
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int HOST_MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_active,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef VGA_FB_ARB_STATS_EN
  ,
  output logic [15:0]       stat_host_stall,
  output logic [15:0]       stat_forced
`endif
);

  localparam int WAIT_W = $clog2(HOST_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(HOST_MAX_WAIT);

  arb_state_t        state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              forced;

  // Last-grant register; the RAM strobe and write enable decode from it.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state is simply whoever owns the RAM this cycle.
  always_comb begin
    state_nxt = IDLE;
    if (disp_gnt)      state_nxt = DISP;
    else if (host_gnt) state_nxt = HOST;
  end

  // Priority grant: starved host, then host in blanking, then display, then host.
  always_comb begin
    disp_gnt = 1'b0;
    host_gnt = 1'b0;
    forced   = 1'b0;
    if (rst) begin
      disp_gnt = 1'b0;
    end else if (host_req && wait_cnt == WAIT_LIM) begin
      host_gnt = 1'b1;
      forced   = 1'b1;
    end else if (!disp_active && host_req) begin
      host_gnt = 1'b1;
    end else if (disp_req) begin
      disp_gnt = 1'b1;
    end else if (host_req) begin
      host_gnt = 1'b1;
    end
  end

  // Count consecutive denied host cycles, saturating at the forcing limit.
  always_ff @(posedge clk) begin
    if (rst || host_gnt || !host_req) wait_cnt <= '0;
    else if (wait_cnt != WAIT_LIM)    wait_cnt <= wait_cnt + 1'b1;
  end

  // Register the granted address and write data for the RAM command cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (host_gnt) begin
      mem_addr  <= host_addr;
      mem_wdata <= host_wdata;
    end else if (disp_gnt) begin
      mem_addr  <= disp_addr;
      mem_wdata <= '0;
    end else begin
      mem_addr  <= '0;
      mem_wdata <= '0;
    end
  end

  // RAM strobe decoded from the registered last-grant state.
  always_comb begin
    mem_en = (state != IDLE);
    mem_we = (state == HOST);
  end

  vga_fb_arb_rdpipe #(.DATA_W(DATA_W)) u_rdpipe (
    .clk       (clk),
    .rst       (rst),
    .rd_issue  (disp_gnt),
    .mem_rdata (mem_rdata),
    .rvalid    (disp_rvalid),
    .rdata     (disp_rdata)
  );

`ifdef VGA_FB_ARB_STATS_EN
  // Saturating counters for host stall cycles and forced host grants.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_host_stall <= '0;
      stat_forced     <= '0;
    end else begin
      if (host_req && !host_gnt && stat_host_stall != 16'hFFFF)
        stat_host_stall <= stat_host_stall + 16'd1;
      if (forced && stat_forced != 16'hFFFF)
        stat_forced <= stat_forced + 16'd1;
    end
  end
`endif

endmodule
